keypad_matrix_scanner: RTL

KEYPAD_MATRIX_SCANNER -- requirements
Module: keypad_matrix_scanner

---
 rtl/keypad_matrix_scanner.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_matrix_scanner.sv
// Purpose: scans a ROWS x COLS key matrix, debounces whole frames, reports single-key presses.
// Latency: press event registered on the edge that closes the DEBOUNCE-th identical frame.
// Backpressure: key_valid/key_ready hold; an event arriving while one is pending is dropped and flagged as overrun.
module keypad_matrix_scanner #(
    parameter int COLS     = 4,
    parameter int ROWS     = 4,
    parameter int DEBOUNCE = 3,
    localparam int CODE_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS-1:0]   col_onehot,
    input  logic [ROWS-1:0]   row_in,
    input  logic              key_ready,
    input  logic              clr_flags,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              multi_key,
    output logic              col_error,
    output logic              overrun
);

    localparam int N = ROWS * COLS;
    localparam logic [3:0]      DEB_C   = 4'(DEBOUNCE);
    localparam logic [COLS-1:0] COL_ONE = COLS'(1);

    // Key map bit layout: bit (row*COLS + col) is 1 when that contact is closed.
    function automatic int unsigned popcnt(input logic [N-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    // Sample path state
    logic [COLS-1:0] col_q;
    logic            col_vld_q;
    logic [COLS-1:0] seen_q, seen_d;
    logic [N-1:0]    fmap_q, fmap_d;

    // Debounce state
    logic [N-1:0]    cand_q, cand_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N-1:0]    acc_q, acc_d;
    logic            multi_q, multi_d;

    // Output / flag state
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              col_err_q, col_err_d;
    logic              ovr_q, ovr_d;

    // Combinational intermediates
    logic              col_is_onehot;
    logic [COLS-1:0]   seen_upd;
    logic [N-1:0]      fmap_upd;
    logic              frame_done;
    logic              bad_col;
    logic              accept;
    logic              press;
    logic [CODE_W-1:0] press_code;
    logic              drop;

    // Merge the row sense into the column that was driven last cycle; close or abort the frame.
    always_comb begin
        col_is_onehot = (col_q != '0) && ((col_q & (col_q - COL_ONE)) == '0);
        seen_upd      = seen_q | col_q;
        fmap_upd      = fmap_q;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (col_q[c]) fmap_upd[r*COLS + c] = row_in[r];
            end
        end
        // col_vld_q masks the reset value of col_q, which is not a real sample.
        frame_done = col_vld_q && col_is_onehot && (&seen_upd);
        bad_col    = col_vld_q && !col_is_onehot;

        seen_d = seen_q;
        fmap_d = fmap_q;
        if (col_vld_q) begin
            if (!col_is_onehot || frame_done) begin
                seen_d = '0;
                fmap_d = '0;
            end else begin
                seen_d = seen_upd;
                fmap_d = fmap_upd;
            end
        end
    end

    // Register the column drive and the partially assembled frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q     <= '0;
            col_vld_q <= 1'b0;
            seen_q    <= '0;
            fmap_q    <= '0;
        end else begin
            col_q     <= col_onehot;
            col_vld_q <= 1'b1;
            seen_q    <= seen_d;
            fmap_q    <= fmap_d;
        end
    end

    // Count identical consecutive frames; accept on the first edge the count reaches DEBOUNCE.
    always_comb begin
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        accept     = 1'b0;
        press      = 1'b0;
        press_code = '0;
        if (frame_done) begin
            if (fmap_upd == cand_q) begin
                if (cnt_q != DEB_C) begin
                    cnt_d  = cnt_q + 4'd1;
                    accept = (cnt_q + 4'd1 == DEB_C);
                end
            end else begin
                cand_d = fmap_upd;
                cnt_d  = 4'd1;
                accept = (DEB_C == 4'd1);
            end
        end
        if (accept) begin
            acc_d = fmap_upd;
            // Only a transition into a different single-key map is a press.
            press = (popcnt(fmap_upd) == 1) && (fmap_upd != acc_q);
            for (int i = 0; i < N; i++) begin
                if (fmap_upd[i]) press_code = CODE_W'(i);
            end
        end
        multi_d = (popcnt(acc_d) > 1);
    end

    // Register the debounce candidate, accepted map and multi-key level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            multi_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            multi_q <= multi_d;
        end
    end

    // Hand the press to the consumer; clear flags take priority over new flag events.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        drop        = 1'b0;
        if (press) begin
            if (!key_valid_q || key_ready) begin
                key_code_d  = press_code;
                key_valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end
        if (clr_flags) begin
            col_err_d = 1'b0;
            ovr_d     = 1'b0;
        end else begin
            col_err_d = col_err_q | bad_col;
            ovr_d     = ovr_q | drop;
        end
    end

    // Register the consumer-facing code/valid and the sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            col_err_q   <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            col_err_q   <= col_err_d;
            ovr_q       <= ovr_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign multi_key = multi_q;
    assign col_error = col_err_q;
    assign overrun   = ovr_q;

endmodule
